// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the ALU, the decoder and the conditional-execution unit.
// Covers the condition-code enumeration, the flag bit positions and the FlagW bit positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator: decides whether Cond passes against a flag vector.
// It is kept free of state so that a branch predictor can share it.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       Pass
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    Pass = 1'b0;
    case (cond_t'(Cond))
      COND_EQ: Pass = z;
      COND_NE: Pass = ~z;
      COND_CS: Pass = c;
      COND_CC: Pass = ~c;
      COND_MI: Pass = n;
      COND_PL: Pass = ~n;
      COND_VS: Pass = v;
      COND_VC: Pass = ~v;
      COND_HI: Pass = c & ~z;
      COND_LS: Pass = ~c | z;
      COND_GE: Pass = (n == v);
      COND_LT: Pass = (n != v);
      COND_GT: Pass = ~z & (n == v);
      COND_LE: Pass = z | (n != v);
      COND_AL: Pass = 1'b1;
      COND_NV: Pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: architectural flag register, per-instruction condition-pass bit,
// and gating of the controller's PC/register/memory write strobes.
module cond_logic
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       InstrValid,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Stall,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic [3:0] flags_r;
  logic       condex_r;
  logic       cond_pass;

  // Evaluated on the registered flags only; ALUFlags never bypass into the decision.
  cond_check u_cond_check (
    .Cond  (Cond),
    .Flags (flags_r),
    .Pass  (cond_pass)
  );

  // The flag write uses the old condex_r, so a decode in the same cycle cannot gate its own
  // predecessor's flag update.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r  <= 4'b0000;
      condex_r <= 1'b0;
    end else if (!Stall) begin
      if (InstrValid) begin
        condex_r <= cond_pass;
      end
      if (FlagW[FW_NZ] && condex_r) begin
        flags_r[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      end
      if (FlagW[FW_CV] && condex_r) begin
        flags_r[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      end
    end
  end

  assign PCSrc    = PCS  & condex_r & ~Stall;
  assign RegWrite = RegW & condex_r & ~NoWrite & ~Stall;
  assign MemWrite = MemW & condex_r & ~Stall;
  assign Flags    = flags_r;
  assign CondEx   = condex_r;

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: stimulus pushes model-predicted outputs per cycle and a
// negedge monitor pops and compares them against the DUT.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       InstrValid = 1'b0;
  logic [3:0] Cond = 4'h0;
  logic [3:0] ALUFlags = 4'h0;
  logic [1:0] FlagW = 2'b00;
  logic       PCS = 1'b0;
  logic       RegW = 1'b0;
  logic       MemW = 1'b0;
  logic       NoWrite = 1'b0;
  logic       Stall = 1'b0;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_logic dut (
    .clk        (clk),
    .reset      (reset),
    .InstrValid (InstrValid),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .NoWrite    (NoWrite),
    .Stall      (Stall),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .Flags      (Flags),
    .CondEx     (CondEx)
  );

  typedef struct {
    bit       valid;
    bit       pcsrc;
    bit       regwrite;
    bit       memwrite;
    bit [3:0] flags;
    bit       condex;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: what the flag register and condition bit should hold right now.
  bit [3:0] m_flags = 4'h0;
  bit       m_cx = 1'b0;
  bit       m_known = 1'b0;

  function automatic bit cond_holds(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Applies one cycle of inputs, predicts outputs for that cycle, then advances the model
  // across the following edge. Returns 1 time unit after that edge.
  task automatic step(input bit rst, input bit iv, input bit [3:0] cnd, input bit [3:0] alu,
                      input bit [1:0] fw, input bit pcs, input bit regw, input bit memw,
                      input bit nowr, input bit stl);
    exp_t e;
    bit new_cx;
    reset = rst; InstrValid = iv; Cond = cnd; ALUFlags = alu; FlagW = fw;
    PCS = pcs; RegW = regw; MemW = memw; NoWrite = nowr; Stall = stl;
    e.valid    = m_known;
    e.pcsrc    = pcs && m_cx && !stl;
    e.regwrite = regw && m_cx && !nowr && !stl;
    e.memwrite = memw && m_cx && !stl;
    e.flags    = m_flags;
    e.condex   = m_cx;
    exp_q.push_back(e);
    if (rst) begin
      m_flags = 4'h0;
      m_cx    = 1'b0;
      m_known = 1'b1;
    end else if (!stl) begin
      new_cx = iv ? cond_holds(cnd, m_flags) : m_cx;
      if (fw[1] && m_cx) m_flags[3:2] = alu[3:2];
      if (fw[0] && m_cx) m_flags[1:0] = alu[1:0];
      m_cx = new_cx;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit pcs, input bit regw, input bit memw);
    step(0, 0, 4'h0, 4'h0, 2'b00, pcs, regw, memw, 0, 0);
  endtask

  // Monitor: outputs are present every cycle, so each negedge consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.valid) begin
        check("pcsrc",    int'(PCSrc),    int'(e.pcsrc));
        check("regwrite", int'(RegWrite), int'(e.regwrite));
        check("memwrite", int'(MemWrite), int'(e.memwrite));
        check("flags",    int'(Flags),    int'(e.flags));
        check("condex",   int'(CondEx),   int'(e.condex));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 300000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset with every request asserted.
    step(1, 1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 0);
    step(1, 1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 0);
    check("reset_flags", int'(Flags), 0);
    check("reset_condex", int'(CondEx), 0);
    idle(1, 1, 1);

    // Flag write and half independence.
    step(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
    check("flagw_11", int'(Flags), 4'b0100);
    step(0, 0, 4'h0, 4'b1011, 2'b01, 0, 0, 0, 0, 0);
    check("flagw_01", int'(Flags), 4'b0111);
    idle(1, 1, 1);

    // Failed condition: clear flags, EQ fails, nothing may be written.
    step(1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    check("eq_fail_condex", int'(CondEx), 0);
    step(0, 0, 4'h0, 4'hF, 2'b11, 1, 1, 1, 0, 0);
    check("eq_fail_flags", int'(Flags), 0);

    // NoWrite on a passing AL instruction.
    step(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 4'h0, 2'b00, 1, 1, 1, 1, 0);

    // Simultaneous decode (EQ) and NZ flag write; flags are 0000 beforehand.
    step(0, 1, 4'h0, 4'b0100, 2'b10, 0, 0, 0, 0, 0);
    check("simul_flags", int'(Flags), 4'b0100);
    check("simul_condex", int'(CondEx), 0);

    // Stall freezes state and blocks the outputs.
    step(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 4'h1, 4'b1010, 2'b11, 1, 1, 1, 0, 1);
    check("stall_flags", int'(Flags), 4'b0100);
    check("stall_condex", int'(CondEx), 1);
    idle(1, 1, 1);

    // Reset mid-instruction.
    step(1, 0, 4'h0, 4'h0, 2'b00, 1, 1, 1, 0, 0);
    check("midreset_condex", int'(CondEx), 0);
    idle(1, 1, 1);

    // Full condition sweep: set flags via AL + FlagW=11, then decode each condition.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        step(0, 1, 4'hE, 4'h0, 2'b00, 1, 1, 1, 0, 0);
        step(0, 0, 4'h0, 4'(f), 2'b11, 0, 0, 0, 0, 0);
        step(0, 1, 4'(c), 4'h0, 2'b00, 0, 0, 0, 0, 0);
      end
    end
    // Spot values from the table: N=1,V=0 gives GE fail, LT pass.
    step(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 0, 4'h0, 4'b1000, 2'b11, 0, 0, 0, 0, 0);
    step(0, 1, 4'hA, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    check("ge_n1v0", int'(CondEx), 0);
    step(0, 1, 4'hB, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    check("lt_n1v0", int'(CondEx), 1);
    step(0, 1, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    check("nv_fails", int'(CondEx), 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 35,
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 15);
    end
    idle(0, 0, 0);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution unit for the multicycle CPU; the consumer of the 4-bit `{N,Z,C,V}` flag vector the ALU produces. It holds the architectural flag register and evaluates the instruction's 4-bit condition field against it at decode. It then gates the controller's PC/register/memory/flag write strobes for the rest of that instruction. It sits between the main decoder and the datapath write enables.

## Interface
- No parameters; all widths fixed by the ISA.
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- InstrValid  in  1  decode strobe; Cond is valid this cycle, captures new condition result.
- Cond  in  4  condition field, Instr[31:28].
- ALUFlags  in  4  ALU flag vector `{N,Z,C,V}`, bit 3 = N … bit 0 = V.
- FlagW  in  2  flag write request: [1] writes N,Z; [0] writes C,V.
- PCS  in  1  controller PC-write request.
- RegW  in  1  controller register-write request.
- MemW  in  1  controller memory-write request.
- NoWrite  in  1  compare-class instruction; suppresses the register write.
- Stall  in  1  hold: freezes all state, forces all write outputs to 0.
- PCSrc  out  1  gated PC write.
- RegWrite  out  1  gated register write.
- MemWrite  out  1  gated memory write.
- Flags  out  4  current flag register `{N,Z,C,V}`.
- CondEx  out  1  registered condition-pass bit for the current instruction.

## Operation
- State: Flags[3:0], CondExR (drives CondEx).
- Condition evaluation (combinational, on registered Flags, never on ALUFlags):
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C.
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 reserved, evaluates 0.
- CondExR: loads the evaluation result on a clock edge with InstrValid=1 and Stall=0. Otherwise holds until the next InstrValid.
- Gated outputs (combinational from CondExR):
  - PCSrc = PCS & CondExR & ~Stall.
  - RegWrite = RegW & CondExR & ~NoWrite & ~Stall.
  - MemWrite = MemW & CondExR & ~Stall.
- Flag write, on the edge, when Stall=0:
  - Flags[3:2] ← ALUFlags[3:2] if FlagW[1] & CondExR.
  - Flags[1:0] ← ALUFlags[1:0] if FlagW[0] & CondExR.
  - Each half is independent; an unwritten half holds.

## Timing
- Reset, on the edge with reset=1: Flags=0000, CondExR=0. Consequently PCSrc=RegWrite=MemWrite=0 and CondEx=0 while held in reset.
- Reset mid-instruction discards CondExR. Write outputs stay 0 until the next InstrValid evaluates a passing condition.
- Reset has priority over Stall, InstrValid and FlagW.
- Condition latency: CondEx valid one cycle after the InstrValid edge, and stays valid through execute/memory/writeback.
- Flag latency: a write at edge k is visible on Flags, and to condition evaluation, from cycle k+1. There is no ALUFlags→condition bypass.
- InstrValid and FlagW in the same cycle:
  - The flag write is gated by the old CondExR (previous instruction).
  - The new condition is evaluated on pre-write Flags.
- Stall=1: no state changes; outputs forced 0. Released outputs resume from the held CondExR.
- Write outputs are purely combinational from state and inputs; no extra cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - `cond_t` enum for the 16 condition codes.
  - Flag index localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FlagW bit localparams FW_NZ=1, FW_CV=0.
- The ALU and the decoder use the same package.
- One sub-module `cond_check`: purely combinational, inputs Cond and Flags, output pass bit. It is reused by any future branch predictor.
- The top holds only the registers and output gating.

## Test plan
- **Reset:**
  - Stimulus: reset high 2 cycles, with PCS=RegW=MemW=1 and FlagW=11.
  - Required: Flags=0000, CondEx=0, all write outputs 0.
- **Flag write and half independence:**
  - Stimulus: AL decode, then FlagW=11 with ALUFlags=0100 → Flags=0100 next cycle.
  - Stimulus: FlagW=01 with ALUFlags=1011 → Flags=0111.
- **Condition table:**
  - Sweep all 16 Cond values over all 16 Flags values.
  - Required: CondEx matches the table, e.g. Flags=1000 with GE → 0, LT → 1; Cond=1111 → 0.
- **Failed condition:**
  - Stimulus: Flags=0000, EQ decode, then PCS=RegW=MemW=1, FlagW=11.
  - Required: all outputs 0, Flags unchanged. NoWrite=1 on a passing AL still gives RegWrite=0.
- **Simultaneous decode and write:**
  - Stimulus: previous CondExR=1, FlagW=10 with ALUFlags=0100, and InstrValid with Cond=EQ in the same cycle.
  - Required: Flags=0100 but CondEx=0, because pre-write Z=0.
- **Stall and mid-reset:**
  - Stall=1 during InstrValid/FlagW leaves CondEx and Flags frozen, with outputs 0.
  - Reset asserted while CondEx=1 clears it the next edge.
